// File: rtl/dvi_tmds_encoder.sv
// Three-channel DVI TMDS encoder: stage 1 builds q_m, stage 2 applies DC balance / control symbols.
// Define DVI_TMDS_CRC_EN to add a per-frame CRC-16/CCITT over the blue input bytes.

module dvi_tmds_channel (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_en,
    input  logic [7:0] i_d,
    input  logic       i_de_s1,
    input  logic       i_c0_s1,
    input  logic       i_c1_s1,
    output logic [9:0] o_tmds
);
    logic [3:0]        w_n1_d;
    logic              w_xnor;
    logic [8:0]        w_qm;
    logic [8:0]        r_qm;
    logic [3:0]        w_n1_q;
    logic signed [5:0] w_diff;
    logic signed [5:0] w_cnt6;
    logic signed [5:0] w_q8x2;
    logic signed [5:0] w_sum;
    logic signed [4:0] w_cnt_nxt;
    logic signed [4:0] r_cnt;
    logic [9:0]        w_sym;
    logic [9:0]        w_ctl;
    logic [9:0]        r_tmds;

    // Stage 1: transition-minimising q_m
    always_comb begin
        w_n1_d = '0;
        for (int i = 0; i < 8; i++)
            w_n1_d = w_n1_d + {3'b000, i_d[i]};
        w_xnor = (w_n1_d > 4'd4) || ((w_n1_d == 4'd4) && !i_d[0]);
        w_qm    = '0;
        w_qm[0] = i_d[0];
        for (int i = 1; i < 8; i++)
            w_qm[i] = w_xnor ? ~(w_qm[i-1] ^ i_d[i]) : (w_qm[i-1] ^ i_d[i]);
        w_qm[8] = ~w_xnor;
    end

    // Stage 2: disparity tracking; N1-N0 of an 8-bit word is 2*N1-8
    always_comb begin
        w_n1_q = '0;
        for (int i = 0; i < 8; i++)
            w_n1_q = w_n1_q + {3'b000, r_qm[i]};
        w_diff = $signed({1'b0, w_n1_q, 1'b0}) - 6'sd8;
        w_cnt6 = {r_cnt[4], r_cnt};
        w_q8x2 = r_qm[8] ? 6'sd2 : 6'sd0;
        if ((r_cnt == 5'sd0) || (w_diff == 6'sd0)) begin
            w_sym = {~r_qm[8], r_qm[8], r_qm[8] ? r_qm[7:0] : ~r_qm[7:0]};
            w_sum = r_qm[8] ? (w_cnt6 + w_diff) : (w_cnt6 - w_diff);
        end else if ((!r_cnt[4] && (w_diff > 6'sd0)) || (r_cnt[4] && (w_diff < 6'sd0))) begin
            w_sym = {1'b1, r_qm[8], ~r_qm[7:0]};
            w_sum = w_cnt6 + w_q8x2 - w_diff;
        end else begin
            w_sym = {1'b0, r_qm[8], r_qm[7:0]};
            w_sum = w_cnt6 + w_diff - (6'sd2 - w_q8x2);
        end
        w_cnt_nxt = w_sum[4:0];
    end

    always_comb begin
        case ({i_c1_s1, i_c0_s1})
            2'b00:   w_ctl = 10'b1101010100;
            2'b01:   w_ctl = 10'b0010101011;
            2'b10:   w_ctl = 10'b0101010100;
            default: w_ctl = 10'b1010101011;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_qm   <= '0;
            r_cnt  <= '0;
            r_tmds <= 10'b1101010100;
        end else if (clk_en) begin
            r_qm <= w_qm;
            if (i_de_s1) begin
                r_tmds <= w_sym;
                r_cnt  <= w_cnt_nxt;
            end else begin
                r_tmds <= w_ctl;
                r_cnt  <= '0;
            end
        end
    end

    assign o_tmds = r_tmds;
endmodule

module dvi_tmds_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_en,
    input  logic [7:0]  red,
    input  logic [7:0]  green,
    input  logic [7:0]  blue,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        de,
    output logic [9:0]  tmds_red,
    output logic [9:0]  tmds_green,
    output logic [9:0]  tmds_blue
`ifdef DVI_TMDS_CRC_EN
    ,
    output logic [15:0] crc_out,
    output logic        crc_valid
`endif
);
    localparam int NUM_CH = 3;

    logic                        r_de_s1;
    logic                        r_hs_s1;
    logic                        r_vs_s1;
    logic [NUM_CH-1:0][7:0]      w_d;
    logic [NUM_CH-1:0][9:0]      w_tmds;
    logic [NUM_CH-1:0]           w_c0;
    logic [NUM_CH-1:0]           w_c1;

    // Channel 0 = blue carries the syncs; red/green send C0=C1=0
    assign w_d  = {red, green, blue};
    assign w_c0 = {1'b0, 1'b0, r_hs_s1};
    assign w_c1 = {1'b0, 1'b0, r_vs_s1};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_de_s1 <= 1'b0;
            r_hs_s1 <= 1'b0;
            r_vs_s1 <= 1'b0;
        end else if (clk_en) begin
            r_de_s1 <= de;
            r_hs_s1 <= hsync;
            r_vs_s1 <= vsync;
        end
    end

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        dvi_tmds_channel u_ch (
            .clk     (clk),
            .rst     (rst),
            .clk_en  (clk_en),
            .i_d     (w_d[ch]),
            .i_de_s1 (r_de_s1),
            .i_c0_s1 (w_c0[ch]),
            .i_c1_s1 (w_c1[ch]),
            .o_tmds  (w_tmds[ch])
        );
    end

    assign tmds_blue  = w_tmds[0];
    assign tmds_green = w_tmds[1];
    assign tmds_red   = w_tmds[2];

`ifdef DVI_TMDS_CRC_EN
    logic [15:0] r_crc_acc;
    logic [15:0] r_crc_out;
    logic        r_crc_vld;
    logic        r_vs_prev;
    logic [15:0] w_crc_nxt;
    logic        w_vs_rise;

    // Byte-wide CRC-16/CCITT, MSB first
    always_comb begin
        w_crc_nxt = r_crc_acc ^ {blue, 8'h00};
        for (int i = 0; i < 8; i++)
            w_crc_nxt = w_crc_nxt[15] ? ((w_crc_nxt << 1) ^ 16'h1021) : (w_crc_nxt << 1);
    end

    assign w_vs_rise = vsync && !r_vs_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_crc_acc <= 16'hFFFF;
            r_crc_out <= '0;
            r_crc_vld <= 1'b0;
            r_vs_prev <= 1'b0;
        end else if (clk_en) begin
            r_vs_prev <= vsync;
            r_crc_vld <= w_vs_rise;
            if (w_vs_rise) begin
                r_crc_out <= r_crc_acc;
                r_crc_acc <= 16'hFFFF;
            end else if (de) begin
                r_crc_acc <= w_crc_nxt;
            end
        end
    end

    assign crc_out   = r_crc_out;
    assign crc_valid = r_crc_vld;
`endif
endmodule

// File: tb/tb_dvi_tmds_encoder.sv
// Directed + randomized bench for dvi_tmds_encoder against a rule-level reference model.
// Covers the CRC outputs too when DVI_TMDS_CRC_EN is defined.

module tb_dvi_tmds_encoder;
    logic       clk = 1'b0;
    logic       rst;
    logic       clk_en;
    logic [7:0] red, green, blue;
    logic       hsync, vsync, de;
    logic [9:0] tmds_red, tmds_green, tmds_blue;
`ifdef DVI_TMDS_CRC_EN
    logic [15:0] crc_out;
    logic        crc_valid;
`endif

    dvi_tmds_encoder dut (
        .clk        (clk),
        .rst        (rst),
        .clk_en     (clk_en),
        .red        (red),
        .green      (green),
        .blue       (blue),
        .hsync      (hsync),
        .vsync      (vsync),
        .de         (de),
        .tmds_red   (tmds_red),
        .tmds_green (tmds_green),
        .tmds_blue  (tmds_blue)
`ifdef DVI_TMDS_CRC_EN
        ,
        .crc_out    (crc_out),
        .crc_valid  (crc_valid)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] r, g, b;
        logic       hs, vs, de;
    } px_t;

    int         n_chk = 0;
    int         n_fail = 0;
    px_t        m_s1;
    logic [9:0] m_exp [3];
    int         m_cnt [3];
    logic [15:0] m_acc, m_crc_out;
    logic        m_crc_vld, m_vs_prev;

    function automatic px_t mk(logic [7:0] r, logic [7:0] g, logic [7:0] b,
                               logic hs, logic vs, logic d);
        px_t p;
        p.r = r; p.g = g; p.b = b; p.hs = hs; p.vs = vs; p.de = d;
        return p;
    endfunction

    function automatic logic [9:0] m_ctl(logic c1, logic c0);
        logic [9:0] s;
        case ({c1, c0})
            2'b00:   s = 10'h354;
            2'b01:   s = 10'h0AB;
            2'b10:   s = 10'h154;
            default: s = 10'h2AB;
        endcase
        return s;
    endfunction

    // q_m bit i is the prefix parity of d[i:0], inverted on odd bits in XNOR mode
    function automatic logic [9:0] m_enc(int ch, logic [7:0] d);
        int         n1d, n1, n0, q8, c;
        logic       xn, p;
        logic [8:0] qm;
        logic [9:0] s;
        n1d = $countones(d);
        xn  = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
        p   = 1'b0;
        for (int i = 0; i < 8; i++) begin
            p     = p ^ d[i];
            qm[i] = p ^ (xn && (i % 2 == 1));
        end
        qm[8] = !xn;
        q8 = qm[8] ? 1 : 0;
        n1 = $countones(qm[7:0]);
        n0 = 8 - n1;
        c  = m_cnt[ch];
        if (c == 0 || n1 == n0) begin
            s = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            c = c + (q8 == 1 ? n1 - n0 : n0 - n1);
        end else if ((c > 0 && n1 > n0) || (c < 0 && n0 > n1)) begin
            s = {1'b1, qm[8], ~qm[7:0]};
            c = c + 2 * q8 + n0 - n1;
        end else begin
            s = {1'b0, qm[8], qm[7:0]};
            c = c + n1 - n0 - 2 * (1 - q8);
        end
        m_cnt[ch] = c;
        return s;
    endfunction

    function automatic logic [15:0] m_crc(logic [15:0] a, logic [7:0] b);
        logic fb;
        for (int i = 7; i >= 0; i--) begin
            fb = a[15] ^ b[i];
            a  = {a[14:0], 1'b0};
            if (fb) a = a ^ 16'h1021;
        end
        return a;
    endfunction

    task automatic m_reset();
        m_s1 = mk(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        for (int ch = 0; ch < 3; ch++) begin
            m_exp[ch] = 10'h354;
            m_cnt[ch] = 0;
        end
        m_acc = 16'hFFFF; m_crc_out = 16'h0000; m_crc_vld = 1'b0; m_vs_prev = 1'b0;
    endtask

    task automatic m_advance(px_t cur);
        if (m_s1.de) begin
            m_exp[0] = m_enc(0, m_s1.b);
            m_exp[1] = m_enc(1, m_s1.g);
            m_exp[2] = m_enc(2, m_s1.r);
        end else begin
            m_exp[0] = m_ctl(m_s1.vs, m_s1.hs);
            m_exp[1] = m_ctl(1'b0, 1'b0);
            m_exp[2] = m_ctl(1'b0, 1'b0);
            for (int ch = 0; ch < 3; ch++) m_cnt[ch] = 0;
        end
        m_s1 = cur;
        if (cur.vs && !m_vs_prev) begin
            m_crc_out = m_acc; m_crc_vld = 1'b1; m_acc = 16'hFFFF;
        end else begin
            m_crc_vld = 1'b0;
            if (cur.de) m_acc = m_crc(m_acc, cur.b);
        end
        m_vs_prev = cur.vs;
    endtask

    task automatic check_val(string tag, logic [15:0] obs, logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        check_val({tag, ".blue"},  {6'd0, tmds_blue},  {6'd0, m_exp[0]});
        check_val({tag, ".green"}, {6'd0, tmds_green}, {6'd0, m_exp[1]});
        check_val({tag, ".red"},   {6'd0, tmds_red},   {6'd0, m_exp[2]});
`ifdef DVI_TMDS_CRC_EN
        check_val({tag, ".crc"},   crc_out, m_crc_out);
        check_val({tag, ".crcv"},  {15'd0, crc_valid}, {15'd0, m_crc_vld});
`endif
    endtask

    task automatic step(string tag, logic en, px_t p);
        clk_en = en; red = p.r; green = p.g; blue = p.b;
        hsync = p.hs; vsync = p.vs; de = p.de;
        @(posedge clk);
        #1;
        if (en) m_advance(p);
        check_all(tag);
    endtask

    // Asynchronous reset asserted between edges must act before the next edge
    task automatic do_reset(string tag);
        rst = 1'b1;
        #1;
        m_reset();
        check_all({tag, ".async"});
        @(posedge clk);
        #1;
        check_all({tag, ".held"});
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       vs_lvl;
        logic       en;
        rst = 1'b1; clk_en = 1'b0; red = 8'h00; green = 8'h00; blue = 8'h00;
        hsync = 1'b0; vsync = 1'b0; de = 1'b0;
        m_reset();
        #1;
        check_all("reset0");
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 4; i++) step("idle", 1'b1, mk(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0));
        check_val("idle.lit", {6'd0, tmds_blue}, 16'h0354);

        step("hs0", 1'b1, mk(8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0));
        check_val("hs0.lit", {6'd0, tmds_blue}, 16'h0354);
        step("hs1", 1'b1, mk(8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0));
        check_val("hs1.blue", {6'd0, tmds_blue}, 16'h00AB);
        check_val("hs1.red",  {6'd0, tmds_red},  16'h0354);
        step("hs2", 1'b1, mk(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0));

        step("b0a", 1'b1, mk(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1));
        step("b0b", 1'b1, mk(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1));
        check_val("b0.sym1", {6'd0, tmds_blue}, 16'h0100);
        step("b0c", 1'b1, mk(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1));
        check_val("b0.sym2", {6'd0, tmds_blue}, 16'h03FF);
        step("b0d", 1'b1, mk(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0));
        check_val("b0.sym3", {6'd0, tmds_blue}, 16'h0100);
        step("b0e", 1'b1, mk(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0));

        step("gFFa", 1'b1, mk(8'h00, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b1));
        step("gFFb", 1'b1, mk(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0));
        check_val("gFF.sym", {6'd0, tmds_green}, 16'h0200);
        step("gFFc", 1'b1, mk(8'h00, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b1));
        check_val("gFF.ctl", {6'd0, tmds_green}, 16'h0354);
        step("gFFd", 1'b1, mk(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0));
        check_val("gFF.cnt0", {6'd0, tmds_green}, 16'h0200);

        vs_lvl = 1'b0;
        for (int ln = 0; ln < 24; ln++) begin
            for (int x = 0; x < 16; x++) begin
                if (ln == 5 && x == 8)
                    for (int k = 0; k < 5; k++)
                        step("gap", 1'b0, mk(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                                             8'($urandom_range(0, 255)), 1'b0, vs_lvl, 1'b1));
                if (ln == 12 && x == 7) do_reset("midrst");
                en = (ln < 4) ? 1'b1 : ($urandom_range(0, 7) != 0);
                step("line", en, mk(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                                    8'($urandom_range(0, 255)), 1'b0, vs_lvl, 1'b1));
            end
            for (int x = 0; x < 4; x++)
                step("blank", 1'b1, mk(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                                       8'($urandom_range(0, 255)), (x == 1 || x == 2), vs_lvl, 1'b0));
            vs_lvl = ((ln % 8) >= 6);
        end

`ifdef DVI_TMDS_CRC_EN
        step("crc.pre", 1'b1, mk(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0));
        do_reset("crcrst");
        step("crc.px", 1'b1, mk(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1));
        step("crc.vs", 1'b1, mk(8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0));
        check_val("crc.lit", crc_out, 16'hE1F0);
        check_val("crc.vld1", {15'd0, crc_valid}, 16'h0001);
        step("crc.hold", 1'b1, mk(8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0));
        check_val("crc.vld0", {15'd0, crc_valid}, 16'h0000);
        check_val("crc.keep", crc_out, 16'hE1F0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
